// File: rtl/fifo_burst_reader.sv
// Burst read engine for the synchronous FIFO: credit-gated reads into a small output buffer, drained on a valid/ready stream.
// Optional running XOR checksum of captured words is built when FIFO_RD_CHECKSUM_EN is defined.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [31:0]           fifo_count,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  burst_done,
    output logic [31:0]           words_read,
    output logic                  err_underflow,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int unsigned PTR_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BEAT_W-1:0]       beats_left;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   obuf [OBUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        obuf_count;
    logic                    rd_gate;
    logic                    push;
    logic                    pop;

    // Credit check counts the word still in flight so the buffer can never overflow.
    assign rd_gate = (state == BURST) && (beats_left != '0) && !fifo_empty &&
                     ((obuf_count + CNT_W'(inflight)) < CNT_W'(OBUF_DEPTH));

    assign fifo_rd_en = rd_gate;
    assign push       = fifo_valid && inflight;
    assign pop        = m_valid && m_ready;
    assign m_valid    = (obuf_count != '0);
    assign m_data     = obuf[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable)
                    state_next = IDLE;
                else if ((fifo_count >= 32'(BURST_LEN)) || (flush && !fifo_empty))
                    state_next = BURST;
            end
            BURST: begin
                if (!inflight && ((beats_left == '0) || (flush && fifo_empty)))
                    state_next = DONE;
            end
            DONE: begin
                state_next = enable ? ARM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            obuf_count    <= '0;
            words_read    <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < int'(OBUF_DEPTH); i++) obuf[i] <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            burst_done <= (state_next == DONE);
            inflight   <= rd_gate;

            if ((state == ARM) && (state_next == BURST))
                beats_left <= BEAT_W'(BURST_LEN);
            else if (rd_gate)
                beats_left <= beats_left - BEAT_W'(1);

            if (push) begin
                obuf[wr_ptr] <= fifo_data_out;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                words_read   <= words_read + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   obuf_count <= obuf_count + CNT_W'(1);
                2'b01:   obuf_count <= obuf_count - CNT_W'(1);
                default: obuf_count <= obuf_count;
            endcase

            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end

`ifdef FIFO_RD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst)
            checksum_q <= '0;
        else if (push)
            checksum_q <= checksum_q ^ fifo_data_out;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed self-checking bench for fifo_burst_reader with a small behavioural FIFO model.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_valid = 1'b0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [31:0]   fifo_count;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          burst_done;
    logic [31:0]   words_read;
    logic          err_underflow;
    logic [DW-1:0] checksum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .OBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_data_out(fifo_data_out), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_count(fifo_count), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .burst_done(burst_done), .words_read(words_read), .err_underflow(err_underflow),
        .checksum(checksum)
    );

    // FIFO model: one-cycle read latency, count optionally overridden.
    logic [DW-1:0] fmem [0:255];
    int unsigned   fhead = 0;
    int unsigned   ftail = 0;
    logic          cnt_force_en = 1'b0;
    logic [31:0]   cnt_force = '0;

    assign fifo_empty = (fhead == ftail);
    assign fifo_count = cnt_force_en ? cnt_force : 32'(ftail - fhead);

    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if (fifo_rd_en && (fhead != ftail)) begin
            fifo_data_out <= fmem[fhead[7:0]];
            fifo_valid    <= 1'b1;
            fhead         <= fhead + 1;
        end
    end

    // Monitor: read strobes, done pulses, stream handshakes.
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            bad_rd = 0;
    logic [DW-1:0] outs [$];

    always @(posedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) rd_cnt++;
            if (fifo_rd_en && fifo_empty) bad_rd++;
            if (burst_done) done_cnt++;
            if (m_valid && m_ready) outs.push_back(m_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fifo_push(input logic [DW-1:0] d);
        fmem[ftail[7:0]] = d;
        ftail = ftail + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_underflow = 1'b0; cnt_force_en = 1'b0;
        ftail = fhead;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        tick(3);
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (burst_done !== 1'b0) begin fails++; $display("FAIL rst_burst_done: got %b want 0", burst_done); end
        tests++; if (words_read !== 32'd0) begin fails++; $display("FAIL rst_words_read: got %0d want 0", words_read); end
        tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_underflow); end
        tests++; if (checksum !== 8'h00) begin fails++; $display("FAIL rst_checksum: got %h want 00", checksum); end
        do_reset();
    endtask

    task automatic test_two_bursts();
        int r0, d0, o0, n, bad;
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) fifo_push(8'(i));
        m_ready = 1'b1;
        r0 = rd_cnt; d0 = done_cnt; o0 = outs.size();
        enable = 1'b1;
        tick(1);
        tests++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin fails++; $display("FAIL arm_cycle: busy=%b rd_en=%b want busy=1 rd_en=0", busy, fifo_rd_en); end
        tick(1);
        tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL first_read: got %b want 1", fifo_rd_en); end
        tick(1);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL latency_early: m_valid got %b want 0", m_valid); end
        tick(1);
        tests++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin fails++; $display("FAIL latency_t2: m_valid=%b m_data=%h want 1/00", m_valid, m_data); end
        wait_done(d0 + 2, 60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL two_bursts_timeout: done pulses got %0d want 2", done_cnt - d0); end
        tick(3);
        n = outs.size() - o0; bad = 0;
        for (int i = 0; i < n && i < 8; i++) if (outs[o0 + i] !== 8'(i)) bad++;
        tests++; if (n != 8 || bad != 0) begin fails++; $display("FAIL two_bursts_order: got %0d words %0d wrong want 8 words 0..7", n, bad); end
        tests++; if (rd_cnt - r0 != 8) begin fails++; $display("FAIL two_bursts_reads: got %0d want 8", rd_cnt - r0); end
        tests++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL two_bursts_done: got %0d want 2", done_cnt - d0); end
        tests++; if (words_read !== 32'd8) begin fails++; $display("FAIL two_bursts_words: got %0d want 8", words_read); end
        tests++; if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL two_bursts_idle_arm: rd_en=%b busy=%b want 0/1", fifo_rd_en, busy); end
    endtask

    task automatic test_backpressure();
        int r0, o0, n, bad;
        do_reset();
        for (int i = 0; i < 8; i++) fifo_push(8'(i));
        m_ready = 1'b0;
        r0 = rd_cnt; o0 = outs.size();
        enable = 1'b1;
        tick(20);
        tests++; if (rd_cnt - r0 != 4) begin fails++; $display("FAIL bp_reads: got %0d want 4", rd_cnt - r0); end
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en_full: got %b want 0", fifo_rd_en); end
        tests++; if (m_valid !== 1'b1 || m_data !== 8'h00) begin fails++; $display("FAIL bp_hold: m_valid=%b m_data=%h want 1/00", m_valid, m_data); end
        tests++; if (words_read !== 32'd4) begin fails++; $display("FAIL bp_words: got %0d want 4", words_read); end
        m_ready = 1'b1;
        for (int i = 0; i < 60 && (outs.size() - o0) < 8; i++) @(negedge clk);
        tick(4);
        n = outs.size() - o0; bad = 0;
        for (int i = 0; i < n && i < 8; i++) if (outs[o0 + i] !== 8'(i)) bad++;
        tests++; if (n != 8 || bad != 0) begin fails++; $display("FAIL bp_order: got %0d words %0d wrong want 8 words 0..7", n, bad); end
        tests++; if (words_read !== 32'd8) begin fails++; $display("FAIL bp_words_total: got %0d want 8", words_read); end
    endtask

    task automatic test_empty_mid_burst();
        int r0, d0, o0, n, bad;
        bit ok;
        do_reset();
        fifo_push(8'h10); fifo_push(8'h11);
        cnt_force = 32'd4; cnt_force_en = 1'b1;
        m_ready = 1'b1;
        r0 = rd_cnt; d0 = done_cnt; o0 = outs.size();
        enable = 1'b1;
        tick(12);
        tests++; if (rd_cnt - r0 != 2) begin fails++; $display("FAIL empty_reads: got %0d want 2", rd_cnt - r0); end
        tests++; if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL empty_stall: rd_en=%b busy=%b want 0/1", fifo_rd_en, busy); end
        tests++; if (done_cnt - d0 != 0) begin fails++; $display("FAIL empty_no_done: got %0d want 0", done_cnt - d0); end
        fifo_push(8'h12); fifo_push(8'h13);
        cnt_force_en = 1'b0;
        wait_done(d0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL empty_resume_timeout: done pulses got %0d want 1", done_cnt - d0); end
        tick(2);
        n = outs.size() - o0; bad = 0;
        for (int i = 0; i < n && i < 4; i++) if (outs[o0 + i] !== 8'(8'h10 + i)) bad++;
        tests++; if (n != 4 || bad != 0) begin fails++; $display("FAIL empty_order: got %0d words %0d wrong want 4 words 10..13", n, bad); end
        tests++; if (rd_cnt - r0 != 4) begin fails++; $display("FAIL empty_total_reads: got %0d want 4", rd_cnt - r0); end
    endtask

    task automatic test_flush();
        int r0, d0, o0, n, bad;
        bit ok;
        do_reset();
        fifo_push(8'h20); fifo_push(8'h21); fifo_push(8'h22);
        m_ready = 1'b1; flush = 1'b1;
        r0 = rd_cnt; d0 = done_cnt; o0 = outs.size();
        enable = 1'b1;
        wait_done(d0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL flush_timeout: done pulses got %0d want 1", done_cnt - d0); end
        tick(6);
        n = outs.size() - o0; bad = 0;
        for (int i = 0; i < n && i < 3; i++) if (outs[o0 + i] !== 8'(8'h20 + i)) bad++;
        tests++; if (rd_cnt - r0 != 3) begin fails++; $display("FAIL flush_reads: got %0d want 3", rd_cnt - r0); end
        tests++; if (n != 3 || bad != 0) begin fails++; $display("FAIL flush_order: got %0d words %0d wrong want 3 words 20..22", n, bad); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL flush_done: got %0d want 1", done_cnt - d0); end
        tests++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin fails++; $display("FAIL flush_arm_empty: busy=%b rd_en=%b want 1/0", busy, fifo_rd_en); end
        tests++; if (bad_rd != 0) begin fails++; $display("FAIL read_while_empty: got %0d want 0", bad_rd); end
        flush = 1'b0;
    endtask

    task automatic test_underflow_reset();
        do_reset();
        fifo_underflow = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set: got %b want 1", err_underflow); end
        tick(5);
        tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
        for (int i = 0; i < 8; i++) fifo_push(8'(8'h40 + i));
        m_ready = 1'b0; enable = 1'b1;
        tick(3);
        tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL midburst_reading: got %b want 1", fifo_rd_en); end
        rst = 1'b1; enable = 1'b0;
        tick(1);
        rst = 1'b0;
        tests++; if (err_underflow !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || burst_done !== 1'b0)
            begin fails++; $display("FAIL midburst_rst_ctrl: err=%b busy=%b rd_en=%b done=%b want all 0", err_underflow, busy, fifo_rd_en, burst_done); end
        tests++; if (m_valid !== 1'b0 || m_data !== 8'h00 || words_read !== 32'd0 || checksum !== 8'h00)
            begin fails++; $display("FAIL midburst_rst_data: m_valid=%b m_data=%h words=%0d csum=%h want 0/00/0/00", m_valid, m_data, words_read, checksum); end
        tick(3);
        tests++; if (m_valid !== 1'b0 || words_read !== 32'd0) begin fails++; $display("FAIL inflight_discard: m_valid=%b words=%0d want 0/0", m_valid, words_read); end
    endtask

    task automatic test_checksum();
        logic [DW-1:0] exp_csum;
        bit ok;
        int d0;
        do_reset();
        fifo_push(8'h01); fifo_push(8'h02); fifo_push(8'h04);
`ifdef FIFO_RD_CHECKSUM_EN
        exp_csum = 8'h07;
`else
        exp_csum = 8'h00;
`endif
        m_ready = 1'b1; flush = 1'b1;
        d0 = done_cnt;
        enable = 1'b1;
        wait_done(d0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL csum_timeout: done pulses got %0d want 1", done_cnt - d0); end
        tests++; if (checksum !== exp_csum) begin fails++; $display("FAIL checksum: got %h want %h", checksum, exp_csum); end
        tests++; if (words_read !== 32'd3) begin fails++; $display("FAIL csum_words: got %0d want 3", words_read); end
        flush = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_backpressure();
        test_empty_mid_burst();
        test_flush();
        test_underflow_reset();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
